// File: rtl/ram_be_pkg.sv
// Shared constants for the byte-enabled RAM: default geometry and the clear value.
package ram_be_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4096;
    localparam int DEF_ADDR_W = 32;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ram_be_array.sv
// Byte-lane storage array: synchronous write, asynchronous read, word-0 nibble tap.
module ram_be_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [NB-1:0]     be,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata,
    output logic [3:0]        tap
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];
    assign tap   = mem[0][3:0];

endmodule

// File: rtl/ram_be.sv
// Byte-enabled single-port RAM with a power-up clear sequence and address checking.
//   state | meaning
//   INIT  | clearing word[cnt] each cycle, requests ignored
//   RUN   | accepting one request per cycle
module ram_be
    import ram_be_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                ready_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                init_done_o,
    output logic [3:0]          res_data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             clearing;
    logic             run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clearing  = 1'b0;
        run       = 1'b0;
        case (state)
            ST_INIT: begin
                clearing = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
        endcase
    end

    // Any address bit above the word index, or a sub-word offset, rejects the request.
    logic [ADDR_W-1:0] addr_hi;
    logic              addr_err;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;
    logic              wr_ok;
    logic              rd_acc;

    assign addr_hi  = addr_i >> (IDX_W + 2);
    assign addr_err = (addr_i[1:0] != 2'b00) || (addr_hi != '0);
    assign req_idx  = addr_i[IDX_W+1:2];
    assign accept   = req_i && run;
    assign wr_ok    = accept && we_i && !addr_err;
    assign rd_acc   = accept && !we_i;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [3:0]        mem_tap;

    assign mem_we    = rst_n && (clearing || wr_ok);
    assign mem_widx  = clearing ? cnt : req_idx;
    assign mem_be    = clearing ? {NB{1'b1}} : be_i;
    assign mem_wdata = clearing ? DATA_W'(ZERO_WORD) : wdata_i;

    ram_be_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .widx  (mem_widx),
        .be    (mem_be),
        .wdata (mem_wdata),
        .ridx  (req_idx),
        .rdata (mem_rdata),
        .tap   (mem_tap)
    );

    logic              rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_acc;
            err_q    <= accept && addr_err;
            if (rd_acc) begin
                rdata_q <= addr_err ? DATA_W'(ZERO_WORD) : mem_rdata;
            end
        end
    end

    assign ready_o     = run;
    assign init_done_o = run;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign res_data_o  = mem_tap;

endmodule

// File: tb/tb_ram_be.sv
// Randomized scoreboard bench for ram_be against a word-array reference model.
module tb_ram_be;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [3:0]    be_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic          ready_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          init_done_o;
    logic [3:0]    res_data_o;

    ram_be #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .init_done_o (init_done_o),
        .res_data_o  (res_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          er;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [DP];
    logic [31:0] exp_hold = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc++;

    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid_o || err_o) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_resp: rvalid=%0b err=%0b at cycle %0d, required none", rvalid_o, err_o, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || rvalid_o != e.rd || err_o != e.er || (e.rd && rdata_o !== e.data)) begin
                        failures++;
                        $display("FAIL response: cyc=%0d rvalid=%0b err=%0b rdata=%h, required cyc=%0d rvalid=%0b err=%0b rdata=%h",
                                 cyc, rvalid_o, err_o, rdata_o, e.cyc, e.rd, e.er, e.data);
                    end
                    if (e.rd) exp_hold = e.data;
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_resp: no response at cycle %0d, required one for request at cycle %0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                checks++;
                if (rdata_o !== exp_hold) begin
                    failures++;
                    $display("FAIL rdata_hold: rdata=%h required %h", rdata_o, exp_hold);
                end
            end
            if (init_done_o === 1'b1) begin
                checks++;
                if (res_data_o !== mem_m[0][3:0]) begin
                    failures++;
                    $display("FAIL res_data: res_data=%h required %h", res_data_o, mem_m[0][3:0]);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step_req(input bit rq, input bit wr, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d, input bit need_rdy);
        bit   rdy;
        bit   er;
        int   w;
        exp_t t;
        req_i = rq; we_i = wr; addr_i = a; be_i = b; wdata_i = d;
        @(negedge clk);
        rdy = ready_o;
        if (need_rdy) begin
            checks++;
            if (!rdy) begin
                failures++;
                $display("FAIL ready_stream: ready=%0b required 1", rdy);
            end
        end
        @(posedge clk);
        #1;
        if (rq && rdy) begin
            er = (a % 4 != 0) || (a >= 4 * DP);
            w  = int'((a / 4) % DP);
            t.cyc = cyc; t.rd = !wr; t.er = er; t.data = '0;
            if (!wr) begin
                if (!er) t.data = mem_m[w];
                q.push_back(t);
            end else if (er) begin
                q.push_back(t);
            end else begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mem_m[w][8*k +: 8] = d[8*k +: 8];
            end
        end
        req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_init();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 4 * DP && !done; i++) begin
            @(negedge clk);
            if (ready_o) done = 1'b1;
            else n++;
        end
        checks++;
        if (!done || n != DP) begin
            failures++;
            $display("FAIL init_len: ready low for %0d cycles (done=%0b), required %0d", n, done, DP);
        end
        checks++;
        if (init_done_o !== 1'b1) begin
            failures++;
            $display("FAIL init_done: init_done=%0b required 1", init_done_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit rd_pending);
        rst_n = 1'b0;
        if (rd_pending) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8;
        end
        @(posedge clk);
        #1;
        q.delete();
        exp_hold = '0;
        for (int i = 0; i < DP; i++) mem_m[i] = '0;
        checks++;
        if (ready_o !== 1'b0 || init_done_o !== 1'b0 || rvalid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== '0) begin
            failures++;
            $display("FAIL reset_state: ready=%0b init_done=%0b rvalid=%0b err=%0b rdata=%h, required all 0",
                     ready_o, init_done_o, rvalid_o, err_o, rdata_o);
        end
        req_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic read_all();
        for (int i = 0; i < DP; i++) step_req(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int sel;
        for (int i = 0; i < DP; i++) mem_m[i] = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        apply_reset(1'b0);
        check_init();

        step_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        step_req(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1);
        step_req(1'b1, 1'b0, 32'(4 * (DP - 1)), 4'h0, 32'h0, 1'b1);
        idle(2);

        step_req(1'b1, 1'b1, 32'h8, 4'b1111, 32'hDEADBEEF, 1'b1);
        step_req(1'b1, 1'b1, 32'h8, 4'b0001, 32'h000000AA, 1'b1);
        step_req(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
        idle(1);

        step_req(1'b1, 1'b1, 32'h0, 4'b1111, 32'h5, 1'b1);
        checks++;
        if (res_data_o !== 4'h5) begin
            failures++;
            $display("FAIL res_data_after_write: res_data=%h required 5", res_data_o);
        end
        idle(1);

        step_req(1'b1, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF, 1'b1);
        step_req(1'b1, 1'b0, 32'h2, 4'h0, 32'h0, 1'b1);
        step_req(1'b1, 1'b0, 32'(4 * DP), 4'h0, 32'h0, 1'b1);
        step_req(1'b1, 1'b1, 32'h9, 4'hF, 32'h11111111, 1'b1);
        step_req(1'b1, 1'b1, 32'(4 * DP + 8), 4'hF, 32'h22222222, 1'b1);
        step_req(1'b1, 1'b1, 32'h8000_0008, 4'hF, 32'h33333333, 1'b1);
        step_req(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            step_req(1'b1, 1'b1, 32'h14, 4'hF, d, 1'b1);
            step_req(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b1);
        end

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) a = 32'($urandom_range(0, 3) * 4);
            else a = 32'($urandom_range(0, DP - 1) * 4);
            if (sel == 0) a = a | 32'($urandom_range(1, 3));
            else if (sel == 1) a = a + 32'(4 * DP * $urandom_range(1, 100));
            else if (sel == 2) a = a | 32'h8000_0000;
            step_req($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a,
                     4'($urandom_range(0, 15)), $urandom, 1'b1);
        end
        idle(2);

        step_req(1'b1, 1'b1, 32'hC, 4'hF, 32'hCAFEF00D, 1'b1);
        step_req(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1);
        apply_reset(1'b1);
        check_init();
        read_all();
        idle(2);

        step_req(1'b1, 1'b1, 32'h0, 4'hF, 32'h0000000A, 1'b1);
        apply_reset(1'b0);
        idle(DP / 2);
        apply_reset(1'b0);
        check_init();
        read_all();
        idle(3);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_be.md
RAM_BE -- requirements
Module: ram_be

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 4096: number of words, a power of two, at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 The block SHALL have clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have rst_n  input  1: reset, synchronous and active-low.
REQ-006 The block SHALL have req_i  input  1: request valid.
REQ-007 The block SHALL have we_i  input  1: 1 = write, 0 = read; sampled with req_i.
REQ-008 The block SHALL have addr_i  input  ADDR_W: byte address.
REQ-009 The block SHALL have be_i  input  DATA_W/8: byte-lane write enables; bit n covers data bits [8n+7:8n].
REQ-010 The block SHALL have wdata_i  input  DATA_W: write data.
REQ-011 The block SHALL have ready_o  output  1: a request is accepted on any edge where req_i && ready_o.
REQ-012 The block SHALL have rvalid_o  output  1: read response valid, a one-cycle pulse.
REQ-013 The block SHALL have rdata_o  output  DATA_W: registered read data.
REQ-014 The block SHALL have err_o  output  1: error pulse for a rejected request.
REQ-015 The block SHALL have init_done_o  output  1: memory clear is complete.
REQ-016 The block SHALL have res_data_o  output  4: bits [3:0] of word 0, combinational from the array.

Function
REQ-017 The block SHALL implement a two-state FSM: INIT and RUN; rst_n low forces INIT with the clear counter at 0.
REQ-018 In INIT the block SHALL write 0 to word[cnt] and increment cnt each cycle; after writing word DEPTH-1 it moves to RUN, so INIT lasts DEPTH cycles.
REQ-019 In INIT ready_o and init_done_o SHALL be 0 and requests SHALL be ignored; in RUN both are 1.
REQ-020 Word index SHALL be addr_i[log2(DEPTH)+1:2].
REQ-021 An accepted request SHALL be in error if addr_i[1:0] != 0 or any addr_i bit above log2(DEPTH)+1 is 1.
REQ-022 An accepted error-free write SHALL update exactly the lanes with be_i set at that edge; be_i = 0 SHALL be a legal no-op.
REQ-023 An accepted read SHALL produce rvalid_o = 1 for one cycle on the following cycle (latency 1), with rdata_o = the word contents before that edge.
REQ-024 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-025 An accepted errored request SHALL not modify memory; err_o SHALL pulse 1 on the next cycle.
REQ-026 For an errored read, rvalid_o SHALL also pulse and rdata_o SHALL be 0.
REQ-027 rdata_o SHALL hold its value between reads.
REQ-028 rvalid_o and err_o SHALL be 0 in any cycle not following an accepted request.
REQ-029 Back-to-back requests SHALL be accepted every RUN cycle, with no bubbles.

Reset
REQ-030 While rst_n is low at an edge, the following SHALL hold after that edge: state = INIT, cnt = 0, rvalid_o = 0, err_o = 0, rdata_o = 0, ready_o = 0, init_done_o = 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear, and any pending read response SHALL be dropped.
REQ-032 Array contents are undefined until INIT completes; res_data_o is valid only while init_done_o = 1.

Structure
REQ-033 The shared defines file SHALL hold the ZERO_WORD constant and the default DATA_W, DEPTH and ADDR_W values; FSM state encodings are local to the block.
REQ-034 The block SHALL contain one sub-module, ram_be_array: a byte-lane-enabled storage array with synchronous write, asynchronous read and a word-0 tap.
REQ-035 The block SHALL keep the FSM, address check and response registers in ram_be.

Verification
REQ-036 The bench SHALL cover: reset then idle -> ready_o = 0 for exactly DEPTH cycles, then init_done_o = 1; reads of words 0, 1 and DEPTH-1 return 0.
REQ-037 The bench SHALL cover: write 0xDEADBEEF at addr 0x8 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read 0x8 -> rdata_o = 0xDEADBEAA, rvalid_o one cycle after acceptance.
REQ-038 The bench SHALL cover: write 0x5 to addr 0 -> res_data_o = 4'h5 the cycle after the write.
REQ-039 The bench SHALL cover: read at addr 0x2 and read at addr 4*DEPTH -> err_o and rvalid_o pulse, rdata_o = 0, memory unchanged.
REQ-040 The bench SHALL cover: a continuous stream of alternating write/read to the same word -> each read returns the preceding write, ready_o never drops.
REQ-041 The bench SHALL cover: rst_n low for 1 cycle mid-stream with a read outstanding -> no rvalid_o, INIT repeats DEPTH cycles, all words read 0.
